// File: rtl/ir_beacon_classifier.sv
// ir_beacon_classifier
//   Measures the frequency of the IR receiver's square wave by counting rising edges over a
//   fixed gate window. Each completed window is classified as the 1 kHz beacon (LOW band), the
//   10 kHz beacon (HIGH band) or neither. The classification is filtered by an N-window
//   confirmation hysteresis before it reaches the outputs.
// Ports
//   clk         system clock
//   Reset       asynchronous active-high reset
//   Enable      synchronous level; 0 holds the block idle and clears the outputs
//   IR_Raw      asynchronous comparator output from the IR receiver
//   IR_1k       confirmed 1 kHz beacon present
//   IR_10k      confirmed 10 kHz beacon present
//   Valid       1-cycle pulse when a new window result is visible
//   Edge_Count  edge count of the last completed window
module ir_beacon_classifier #(
    parameter int unsigned GATE_CYCLES = 10_000_000,
    parameter int unsigned LO_MIN      = 80,
    parameter int unsigned LO_MAX      = 120,
    parameter int unsigned HI_MIN      = 800,
    parameter int unsigned HI_MAX      = 1200,
    parameter int unsigned CONFIRM     = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             IR_Raw,
    output logic             IR_1k,
    output logic             IR_10k,
    output logic             Valid,
    output logic [CNT_W-1:0] Edge_Count
);

    localparam int unsigned WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned PND_W = $clog2(CONFIRM + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);

    typedef enum logic {StIdle, StMeasure} state_t;
    typedef enum logic [1:0] {ClsNone, ClsLow, ClsHigh} cls_t;

    state_t           state;
    cls_t             cls;
    cls_t             pend_cls;
    logic [PND_W-1:0] pend_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             latch;

    logic             edge_det;
    logic [CNT_W-1:0] edge_sum;
    logic [31:0]      ec;
    cls_t             cand;
    cls_t             cls_n;
    cls_t             pend_cls_n;
    logic [PND_W-1:0] pend_cnt_n;
    logic [31:0]      pend_inc;

    // sync2 is the synchronized level; sync3 is its one-cycle delay for edge detection.
    assign edge_det = sync2 & ~sync3;

    // Saturating add: an edge in the latch cycle itself is included in edge_sum.
    always_comb begin
        edge_sum = edge_cnt;
        if (edge_cnt != '1) begin
            edge_sum = edge_cnt + CNT_W'(edge_det);
        end
    end

    // Band decode of the latched count; LOW takes priority if bands were to overlap.
    always_comb begin
        ec   = 32'(Edge_Count);
        cand = ClsNone;
        if (Edge_Count == '1) begin
            cand = ClsNone;
        end else if (ec >= LO_MIN && ec <= LO_MAX) begin
            cand = ClsLow;
        end else if (ec >= HI_MIN && ec <= HI_MAX) begin
            cand = ClsHigh;
        end
    end

    // Confirmation hysteresis next-state.
    always_comb begin
        cls_n      = cls;
        pend_cls_n = pend_cls;
        pend_cnt_n = pend_cnt;
        pend_inc   = 32'(pend_cnt) + 32'd1;
        if (cand == cls) begin
            pend_cnt_n = '0;
        end else if (cand == pend_cls) begin
            if (pend_inc >= CONFIRM) begin
                cls_n      = cand;
                pend_cnt_n = '0;
            end else begin
                pend_cnt_n = PND_W'(pend_inc);
            end
        end else begin
            pend_cls_n = cand;
            if (CONFIRM == 1) begin
                cls_n      = cand;
                pend_cnt_n = '0;
            end else begin
                pend_cnt_n = PND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= StIdle;
            cls        <= ClsNone;
            pend_cls   <= ClsNone;
            pend_cnt   <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            latch      <= 1'b0;
            IR_1k      <= 1'b0;
            IR_10k     <= 1'b0;
            Valid      <= 1'b0;
            Edge_Count <= '0;
        end else begin
            sync1 <= IR_Raw;
            sync2 <= sync1;
            sync3 <= sync2;
            Valid <= 1'b0;
            latch <= 1'b0;
            case (state)
                StIdle: begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    if (Enable) begin
                        state <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (!Enable) begin
                        // Abort: partial window dropped, Edge_Count keeps the last result.
                        state    <= StIdle;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                        cls      <= ClsNone;
                        pend_cls <= ClsNone;
                        pend_cnt <= '0;
                        IR_1k    <= 1'b0;
                        IR_10k   <= 1'b0;
                    end else begin
                        if (win_cnt == WIN_LAST) begin
                            Edge_Count <= edge_sum;
                            edge_cnt   <= '0;
                            win_cnt    <= '0;
                            latch      <= 1'b1;
                        end else begin
                            edge_cnt <= edge_sum;
                            win_cnt  <= win_cnt + WIN_W'(1);
                        end
                        // Classify the count latched in the previous cycle.
                        if (latch) begin
                            cls      <= cls_n;
                            pend_cls <= pend_cls_n;
                            pend_cnt <= pend_cnt_n;
                            IR_1k    <= (cls_n == ClsLow);
                            IR_10k   <= (cls_n == ClsHigh);
                            Valid    <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_beacon_classifier.sv
// Directed bench for ir_beacon_classifier with a queue scoreboard: each full window pushes its
// hand-computed result; a monitor pops and compares whenever Valid is seen.
module tb_ir_beacon_classifier;

    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             Reset;
    logic             Enable;
    logic             IR_Raw;
    logic             IR_1k;
    logic             IR_10k;
    logic             Valid;
    logic [CNT_W-1:0] Edge_Count;

    typedef struct {
        int cnt;
        bit lo;
        bit hi;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ir_beacon_classifier #(
        .GATE_CYCLES(1000),
        .LO_MIN     (8),
        .LO_MAX     (12),
        .HI_MIN     (80),
        .HI_MAX     (120),
        .CONFIRM    (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .IR_Raw    (IR_Raw),
        .IR_1k     (IR_1k),
        .IR_10k    (IR_10k),
        .Valid     (Valid),
        .Edge_Count(Edge_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One-cycle pulses with spacing 990/n; either starting at offset 2 or ending at offset 998.
    function automatic logic pulse_at(input int n, input bit at998, input int j);
        int s;
        int d;
        if (n == 0) return 1'b0;
        s = 990 / n;
        d = at998 ? (998 - j) : (j - 2);
        return (d >= 0) && (d % s == 0) && (d / s < n);
    endfunction

    // Offset j is sampled on the posedge after its negedge; a rise at offset j is counted at
    // window index j+1, so offsets 0..998 stay inside the window that offset 0 starts.
    task automatic drive_window(input int n, input bit at998, input int stop_at, input bit push,
                                input int e_cnt, input bit e_lo, input bit e_hi);
        exp_t e;
        if (push) begin
            e.cnt = e_cnt;
            e.lo  = e_lo;
            e.hi  = e_hi;
            sb.push_back(e);
        end
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            if (j == 0) begin
                Reset  = 1'b0;
                Enable = 1'b1;
            end
            if (j == stop_at) begin
                IR_Raw = 1'b0;
                return;
            end
            IR_Raw = pulse_at(n, at998, j);
        end
    endtask

    // Monitor: every Valid must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (Valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("edge_count", int'(Edge_Count), e.cnt);
                    chk("ir_1k", int'(IR_1k), int'(e.lo));
                    chk("ir_10k", int'(IR_10k), int'(e.hi));
                    chk("not_both", int'(IR_1k & IR_10k), 0);
                end
            end
        end
    end

    initial begin
        int lat;
        Reset  = 1'b1;
        Enable = 1'b0;
        IR_Raw = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ir_1k", int'(IR_1k), 0);
        chk("rst_ir_10k", int'(IR_10k), 0);
        chk("rst_valid", int'(Valid), 0);
        chk("rst_edge_count", int'(Edge_Count), 0);

        // 1 kHz acquisition
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b0, 1'b0);
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b1, 1'b0);
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b1, 1'b0);
        // 10 kHz then back to 1 kHz
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b1, 1'b0);
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b0, 1'b1);
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b0, 1'b1);
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b0, 1'b1);
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b1, 1'b0);
        // single dark window is rejected
        drive_window(0, 1'b0, -1, 1'b1, 0, 1'b1, 1'b0);
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b1, 1'b0);
        // band boundaries
        drive_window(7, 1'b0, -1, 1'b1, 7, 1'b1, 1'b0);
        drive_window(8, 1'b0, -1, 1'b1, 8, 1'b1, 1'b0);
        drive_window(12, 1'b0, -1, 1'b1, 12, 1'b1, 1'b0);
        drive_window(13, 1'b0, -1, 1'b1, 13, 1'b1, 1'b0);
        drive_window(120, 1'b0, -1, 1'b1, 120, 1'b1, 1'b0);
        drive_window(120, 1'b0, -1, 1'b1, 120, 1'b0, 1'b1);
        drive_window(121, 1'b0, -1, 1'b1, 121, 1'b0, 1'b1);
        drive_window(80, 1'b0, -1, 1'b1, 80, 1'b0, 1'b1);
        drive_window(79, 1'b0, -1, 1'b1, 79, 1'b0, 1'b1);
        // 200 edges saturate the 7-bit counter at 127 -> NONE, confirms the pending NONE
        drive_window(200, 1'b0, -1, 1'b1, 127, 1'b0, 1'b0);
        // last edge lands on window index 999
        drive_window(8, 1'b1, -1, 1'b1, 8, 1'b0, 1'b0);
        drive_window(8, 1'b1, -1, 1'b1, 8, 1'b1, 1'b0);

        // Enable dropped mid-window
        drive_window(10, 1'b0, 500, 1'b0, 0, 1'b0, 1'b0);
        Enable = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_ir_1k", int'(IR_1k), 0);
        chk("drop_ir_10k", int'(IR_10k), 0);
        chk("drop_valid", int'(Valid), 0);
        chk("drop_edge_count_hold", int'(Edge_Count), 8);
        repeat (20) @(negedge clk);

        // Re-enable: first Valid 1001 cycles after the enable cycle
        fork
            drive_window(10, 1'b0, -1, 1'b1, 10, 1'b0, 1'b0);
            begin
                @(negedge clk);
                @(posedge clk);
                lat = -1;
                for (int k = 1; k <= 3000; k++) begin
                    @(posedge clk);
                    #1;
                    if (Valid === 1'b1) begin
                        lat = k;
                        break;
                    end
                end
                chk("reenable_latency", lat, 1001);
            end
        join
        drive_window(10, 1'b0, -1, 1'b1, 10, 1'b1, 1'b0);
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b1, 1'b0);
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b0, 1'b1);

        // Asynchronous reset mid-window
        drive_window(100, 1'b0, 300, 1'b0, 0, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_ir_1k", int'(IR_1k), 0);
        chk("arst_ir_10k", int'(IR_10k), 0);
        chk("arst_valid", int'(Valid), 0);
        chk("arst_edge_count", int'(Edge_Count), 0);
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b0, 1'b0);
        drive_window(100, 1'b0, -1, 1'b1, 100, 1'b0, 1'b1);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
